// File: rtl/audio_pkg.sv
// Shared audio constants and helpers used by the volume stage and the music generator.
package audio_pkg;

  localparam int LEVEL_W   = 3;
  localparam int LEVEL_MAX = 7;

  // Duck FSM encoding.
  typedef enum logic {
    DK_IDLE = 1'b0,
    DK_DUCK = 1'b1
  } duck_state_e;

  // Milliseconds to clock cycles. Evaluated at elaboration only.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF sync -> debounced state -> one-cycle press pulse.
// A key already held when reset releases is ignored until it has been seen
// released, so reset never produces a press.
module key_debounce #(
  parameter int DB_CYC = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  // Counter holds 0..DB_CYC-1.
  localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  logic [1:0]       sync_q;
  logic [1:0]       warm_q;
  logic             armed_q;
  logic             db_q, db_d1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Synchronizer (idle = released) plus a warm-up marker for when its output is real data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      warm_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      warm_q <= {warm_q[0], 1'b1};
    end
  end

  // Arm only after a genuine released sample has come through the synchronizer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) armed_q <= 1'b0;
    else         armed_q <= armed_q | (warm_q[1] & sync_q[1]);
  end

  // Debounce: accept a change only after it has held for DB_CYC cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q  <= 1'b1;
      cnt_q <= '0;
    end else if (sync_q[1] == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      db_q  <= sync_q[1];
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered pulse on a debounced 1->0 (press) edge only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_d1_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      db_d1_q <= db_q;
      press_q <= armed_q & db_d1_q & ~db_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/volume_ctrl.sv
// Player volume stage: debounced up/down keys, mute switch and timed half-volume duck
// feeding the music generator's registered level input.
module volume_ctrl
  import audio_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int DUCK_MS       = 500,
  parameter int DEFAULT_LEVEL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up_n,
  input  logic               btn_dn_n,
  input  logic               sw_mute,
  input  logic               duck_req,
  output logic [LEVEL_W-1:0] level,
  output logic               muted,
  output logic               ducking
);

  localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int DUCK_CYC = ms_to_cyc(CLK_HZ, DUCK_MS) - 1;
  localparam int TMR_W    = (DUCK_CYC > 0) ? $clog2(DUCK_CYC + 1) : 1;

  localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(DUCK_CYC);
  localparam logic [LEVEL_W-1:0] VOL_MAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] VOL_RST  = LEVEL_W'(DEFAULT_LEVEL);

  logic               up_p, dn_p;
  logic [1:0]         mute_sync_q;
  logic [LEVEL_W-1:0] vol_q, vol_d;
  duck_state_e        dk_state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               ducking_q, muted_q;
  logic [LEVEL_W-1:0] level_q;

  key_debounce #(.DB_CYC(DB_CYC)) u_key_up (
    .clk_i(clk), .rst_ni(rst), .key_n_i(btn_up_n), .press_o(up_p)
  );

  key_debounce #(.DB_CYC(DB_CYC)) u_key_dn (
    .clk_i(clk), .rst_ni(rst), .key_n_i(btn_dn_n), .press_o(dn_p)
  );

  // Mute switch synchronizer (idle = unmuted).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mute_sync_q <= 2'b00;
    else      mute_sync_q <= {mute_sync_q[0], sw_mute};
  end

  // Saturating volume step; simultaneous up and down cancel.
  always_comb begin
    vol_d = vol_q;
    if (up_p && !dn_p && vol_q != VOL_MAX)    vol_d = vol_q + 1'b1;
    else if (dn_p && !up_p && vol_q != '0)    vol_d = vol_q - 1'b1;
  end

  // Volume register keeps tracking keys while muted or ducking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vol_q <= VOL_RST;
    else      vol_q <= vol_d;
  end

  // Duck FSM: retriggerable one-shot with registered ducking flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dk_state_q <= DK_IDLE;
      tmr_q      <= '0;
      ducking_q  <= 1'b0;
    end else begin
      case (dk_state_q)
        DK_IDLE: begin
          if (duck_req) begin
            tmr_q      <= TMR_LOAD;
            dk_state_q <= DK_DUCK;
            ducking_q  <= 1'b1;
          end
        end
        DK_DUCK: begin
          if (duck_req) begin
            tmr_q <= TMR_LOAD;
          end else if (tmr_q == '0) begin
            dk_state_q <= DK_IDLE;
            ducking_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          dk_state_q <= DK_IDLE;
          ducking_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: mute beats duck beats plain volume. Mute uses the synced
  // switch directly so level and muted change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= VOL_RST;
      muted_q <= 1'b0;
    end else begin
      muted_q <= mute_sync_q[1];
      if (mute_sync_q[1]) level_q <= '0;
      else if (ducking_q) level_q <= vol_q >> 1;
      else                level_q <= vol_q;
    end
  end

  assign level   = level_q;
  assign muted   = muted_q;
  assign ducking = ducking_q;

endmodule

// File: tb/tb_volume_ctrl.sv
// Scoreboard bench for volume_ctrl: stimulus queues expected outputs tagged with
// the edge count at which they must hold; a monitor compares them on negedges.
module tb_volume_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up_n = 1'b1;
  logic       btn_dn_n = 1'b1;
  logic       sw_mute = 1'b0;
  logic       duck_req = 1'b0;
  logic [2:0] level;
  logic       muted;
  logic       ducking;

  int cyc;
  int errors = 0;
  int checks = 0;
  int model_vol;

  typedef struct {
    int         at;
    logic [2:0] lvl;
    logic       m;
    logic       d;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  volume_ctrl #(
    .CLK_HZ(10_000), .DEBOUNCE_MS(2), .DUCK_MS(5), .DEFAULT_LEVEL(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .sw_mute(sw_mute), .duck_req(duck_req),
    .level(level), .muted(muted), .ducking(ducking)
  );

  always #5 clk = ~clk;

  // Edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic expect_at(input int at, input int lvl, input bit m, input bit d, input string nm);
    exp_t e;
    e.at = at; e.lvl = 3'(lvl); e.m = m; e.d = d; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(3);
    rst = 1'b1;
  endtask

  task automatic bump(input bit up);
    if (up) model_vol = (model_vol == 7) ? 7 : model_vol + 1;
    else    model_vol = (model_vol == 0) ? 0 : model_vol - 1;
  endtask

  // Clean press: hold 30 edges, release, let release settle 30 edges.
  task automatic press(input bit up);
    if (up) btn_up_n = 1'b0; else btn_dn_n = 1'b0;
    step(30);
    btn_up_n = 1'b1; btn_dn_n = 1'b1;
    step(30);
  endtask

  // Monitor: pop every entry due at this edge count and compare.
  always @(negedge clk) begin
    if (rst) begin
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
        mon_e = sbq.pop_front();
        checks++;
        if (mon_e.at < cyc) begin
          errors++;
          $display("FAIL %s: missed slot at edge %0d (now %0d)", mon_e.name, mon_e.at, cyc);
        end else if (level !== mon_e.lvl || muted !== mon_e.m || ducking !== mon_e.d) begin
          errors++;
          $display("FAIL %s @%0d: got level=%0d muted=%0b ducking=%0b, want level=%0d muted=%0b ducking=%0b",
                   mon_e.name, cyc, level, muted, ducking, mon_e.lvl, mon_e.m, mon_e.d);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int c, u;

    // Reset released with up key held: no step, release produces none either.
    btn_up_n = 1'b0;
    #1;
    do_reset();
    model_vol = 3;
    expect_at(1,  3, 0, 0, "reset_state");
    expect_at(30, 3, 0, 0, "held_at_reset_a");
    expect_at(60, 3, 0, 0, "held_at_reset_b");
    expect_at(100, 3, 0, 0, "held_release");
    step(60);
    btn_up_n = 1'b1;
    step(40);

    // Single press latency: first low sample at c+1, level at c+25.
    c = cyc;
    expect_at(c + 24, 3, 0, 0, "up_latency_early");
    bump(1);
    expect_at(c + 25, model_vol, 0, 0, "up_latency");
    press(1);

    // Saturation at 7, then at 0 without wrap.
    for (int i = 0; i < 5; i++) begin
      c = cyc; bump(1);
      expect_at(c + 25, model_vol, 0, 0, "up_sat");
      press(1);
    end
    for (int i = 0; i < 10; i++) begin
      c = cyc; bump(0);
      expect_at(c + 25, model_vol, 0, 0, "dn_sat");
      press(0);
    end

    // Bounce shorter than the debounce window: no step.
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries pending, want 0", sbq.size());
    end
    do_reset();
    model_vol = 3;
    expect_at(50,  3, 0, 0, "bounce_mid");
    expect_at(100, 3, 0, 0, "bounce_end");
    expect_at(140, 3, 0, 0, "bounce_settled");
    for (int k = 0; k < 5; k++) begin
      btn_up_n = 1'b0; step(10);
      btn_up_n = 1'b1; step(10);
    end
    step(40);

    // Raise to 6, then duck with a retrigger at +30.
    for (int i = 0; i < 3; i++) begin
      c = cyc; bump(1);
      expect_at(c + 25, model_vol, 0, 0, "pre_duck_up");
      press(1);
    end
    c = cyc;
    expect_at(c + 1,  6, 0, 1, "duck_flag");
    expect_at(c + 2,  3, 0, 1, "duck_half");
    expect_at(c + 50, 3, 0, 1, "duck_retrig_mid");
    expect_at(c + 80, 3, 0, 1, "duck_retrig_hold");
    expect_at(c + 81, 3, 0, 0, "duck_end");
    expect_at(c + 82, 6, 0, 0, "duck_restore");
    duck_req = 1'b1; step(1); duck_req = 1'b0;
    step(29);
    duck_req = 1'b1; step(1); duck_req = 1'b0;
    step(60);

    // Mute during duck, press up while muted, unmute after duck ends.
    c = cyc;
    expect_at(c + 4, 3, 0, 1, "mute_pending");
    expect_at(c + 5, 0, 1, 1, "mute_on");
    duck_req = 1'b1; step(1); duck_req = 1'b0;
    step(1);
    sw_mute = 1'b1;
    step(4);
    bump(1);
    expect_at(c + 31, 0, 1, 1, "mute_up_press");
    expect_at(c + 52, 0, 1, 0, "mute_after_duck");
    press(1);
    u = cyc;
    expect_at(u + 2, 0, 1, 0, "unmute_pending");
    expect_at(u + 3, model_vol, 0, 0, "unmute_level");
    sw_mute = 1'b0;
    step(10);

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries pending, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
